// File: rtl/mips_mem_pkg.sv
// Shared definitions for the multi-cycle data-memory path: FSM encoding, word geometry
// and the data returned on an error response.
package mips_mem_pkg;

  localparam int WORD_W     = 16;
  localparam int BYTE_SHIFT = 2;
  localparam int IDX_W      = WORD_W - BYTE_SHIFT;
  localparam logic [WORD_W-1:0] ERR_DATA = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef logic [IDX_W-1:0] idx_t;

  function automatic idx_t word_idx(input logic [WORD_W-1:0] byte_addr);
    return byte_addr[WORD_W-1:BYTE_SHIFT];
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request bus between the CPU (master) and the data-memory responder (slave).
// The master holds req/we/addr/wdata until it sees the ack pulse.
interface dmem_responder_if;

  logic                              req;
  logic                              we;
  logic [mips_mem_pkg::WORD_W-1:0]   addr;
  logic [mips_mem_pkg::WORD_W-1:0]   wdata;
  logic                              ack;
  logic [mips_mem_pkg::WORD_W-1:0]   rdata;
  logic                              err;
  logic                              busy;

  modport master (output req, we, addr, wdata, input ack, rdata, err, busy);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err, busy);

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 16 word store: synchronous write, synchronous registered read, no reset.
// Latency: read data valid the cycle after ren; never stalls.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wen,
  input  logic              ren,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wen) mem[addr] <= wdata;
    if (ren) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one lw/sw per req/ack, ack WAIT_STATES+1 cycles after accept.
// Backpressure: busy from acceptance through the ack cycle; req is only sampled in IDLE or at the end of RESP.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input logic             clock,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [3:0]  WS      = 4'(WAIT_STATES);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [WORD_W-1:0] addr_q, wdata_q, rdata_q, arr_rdata;
  logic              accept, commit, bad, load_ok, arr_wen, arr_ren;

  always_comb begin
    accept  = bus.req && (state_q == ST_IDLE || state_q == ST_RESP);
    commit  = (state_q == ST_WAIT) && (cnt_q == WS);
    bad     = (addr_q[BYTE_SHIFT-1:0] != '0) || (32'(word_idx(addr_q)) >= DEPTH_U);
    load_ok = !we_q && !bad;
    // A reset landing on the commit edge must not let the store through.
    arr_wen = commit && we_q && !bad && !reset;
    arr_ren = commit && load_ok;
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // RESP may chain straight into WAIT so a held req gets back-to-back service.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req) state_d = ST_WAIT;
      ST_WAIT: if (commit)  state_d = ST_RESP;
      ST_RESP: state_d = bus.req ? ST_WAIT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= ERR_DATA;
    end else begin
      if (accept) begin
        cnt_q   <= '0;
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end else if (state_q == ST_WAIT && !commit) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if (commit && bad) rdata_q <= ERR_DATA;
      // Array output is live during RESP; keep a copy so rdata holds until the next ack.
      if (state_q == ST_RESP && load_ok) rdata_q <= arr_rdata;
    end
  end

  always_comb begin
    bus.ack   = (state_q == ST_RESP);
    bus.busy  = (state_q != ST_IDLE);
    bus.err   = bus.ack && bad;
    bus.rdata = (bus.ack && load_ok) ? arr_rdata : rdata_q;
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clock (clock),
    .wen   (arr_wen),
    .ren   (arr_ren),
    .addr  (addr_q[BYTE_SHIFT +: AW]),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random lw/sw traffic on a WAIT_STATES=2
// and a WAIT_STATES=0 instance, checked against an associative-array memory model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2, rst0;
  dmem_responder_if bus2 ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH(1024), .WAIT_STATES(2)) u_dut2 (.clock(clk), .reset(rst2), .bus(bus2.slave));
  dmem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (.clock(clk), .reset(rst0), .bus(bus0.slave));

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] mdl [int];
  logic [15:0] last_rd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // sel=0 -> WAIT_STATES=2 instance, sel=1 -> WAIT_STATES=0 instance
  task automatic drive(input bit sel, input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    if (sel) begin bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wdata = d; end
    else     begin bus2.req = r; bus2.we = w; bus2.addr = a; bus2.wdata = d; end
  endtask

  // {ack, err, busy, rdata}
  function automatic logic [18:0] outs(input bit sel);
    return sel ? {bus0.ack, bus0.err, bus0.busy, bus0.rdata}
               : {bus2.ack, bus2.err, bus2.busy, bus2.rdata};
  endfunction

  function automatic bit is_bad(input logic [15:0] a);
    return (a[1:0] != 2'b00) || (int'(a) / 4 >= 1024);
  endfunction

  function automatic int mkey(input bit sel, input logic [15:0] a);
    return (sel ? 65536 : 0) + int'(a) / 4;
  endfunction

  task automatic txn(input bit sel, input logic w, input logic [15:0] a, input logic [15:0] d, input bit scramble);
    int          lat = sel ? 0 : 2;
    int          n = 0;
    logic [18:0] o;
    bit          bad = is_bad(a);
    bit          known = 1'b1;
    logic [15:0] exp;
    if (bad)                      exp = 16'h0000;
    else if (w)                   exp = last_rd[sel];
    else if (mdl.exists(mkey(sel, a))) exp = mdl[mkey(sel, a)];
    else begin known = 1'b0; exp = 16'h0000; end
    @(negedge clk);
    drive(sel, 1'b1, w, a, d);
    do begin
      @(negedge clk);
      n++;
      o = outs(sel);
      if (n == 1) begin
        check("busy_after_accept", 32'(o[16]), 32'd1);
        if (scramble) drive(sel, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
      end
    end while (!o[18] && n < 40);
    drive(sel, 1'b0, 1'b0, 16'h0, 16'h0);
    if (!o[18]) begin
      check("ack_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", 32'(n), 32'(lat + 2));
    check("err", 32'(o[17]), 32'(bad));
    if (known) check("rdata", 32'(o[15:0]), 32'(exp));
    if (!bad && w) mdl[mkey(sel, a)] = d;
    if (known) last_rd[sel] = exp;
    @(negedge clk);
    o = outs(sel);
    check("ack_one_cycle", 32'(o[18]), 32'd0);
    check("busy_idle", 32'(o[16]), 32'd0);
    if (known) check("rdata_hold", 32'(o[15:0]), 32'(exp));
  endtask

  initial begin
    logic [18:0] o;
    int          acks, last, cyc, seen;
    logic [15:0] a, r0, r4;

    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    rst2 = 1'b1; rst0 = 1'b1;
    repeat (3) @(negedge clk);
    rst2 = 1'b0; rst0 = 1'b0;
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    for (int s = 0; s < 2; s++) begin
      o = outs(s[0]);
      check("reset_outputs", 32'(o), 32'd0);
    end

    // Basic store then load, misaligned store, range boundary
    txn(1'b0, 1'b1, 16'h0004, 16'h0007, 1'b0);
    txn(1'b0, 1'b0, 16'h0004, 16'h0000, 1'b1);
    txn(1'b0, 1'b1, 16'h0006, 16'hBEEF, 1'b0);
    txn(1'b0, 1'b0, 16'h0004, 16'h0000, 1'b0);
    txn(1'b0, 1'b1, 16'h0FFC, 16'hA55A, 1'b0);
    txn(1'b0, 1'b0, 16'h1000, 16'h0000, 1'b0);
    txn(1'b0, 1'b0, 16'h0FFC, 16'h0000, 1'b0);

    // Reset one cycle after acceptance discards the pending store
    txn(1'b0, 1'b1, 16'h0008, 16'h5A5A, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'h0008, 16'h1234);
    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    o = outs(1'b0);
    check("reset_mid_busy", 32'(o[16]), 32'd0);
    check("reset_mid_ack", 32'(o[18]), 32'd0);
    check("reset_mid_rdata", 32'(o[15:0]), 32'd0);
    rst2 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    last_rd[0] = 16'h0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus2.ack) seen++;
    end
    check("no_ack_after_reset", 32'(seen), 32'd0);
    txn(1'b0, 1'b0, 16'h0008, 16'h0000, 1'b0);

    // Held req: back-to-back loads every WAIT_STATES+2 cycles
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0);
    acks = 0; last = -1; cyc = 0;
    while (acks < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      o = outs(1'b0);
      if (o[18]) begin
        check("hold_rdata", 32'(o[15:0]), 32'h0007);
        if (last < 0) check("hold_first_latency", 32'(cyc), 32'd4);
        else          check("hold_spacing", 32'(cyc - last), 32'd4);
        last = cyc;
        acks++;
        if (acks == 4) drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      end
    end
    check("hold_ack_count", 32'(acks), 32'd4);
    last_rd[0] = 16'h0007;
    @(negedge clk);
    o = outs(1'b0);
    check("hold_release_idle", 32'(o[18:16]), 32'd0);

    // Zero-wait-state swap of two words
    txn(1'b1, 1'b1, 16'h0000, 16'h0005, 1'b0);
    txn(1'b1, 1'b1, 16'h0004, 16'h0007, 1'b0);
    txn(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    r0 = last_rd[1];
    txn(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
    r4 = last_rd[1];
    txn(1'b1, 1'b1, 16'h0000, r4, 1'b0);
    txn(1'b1, 1'b1, 16'h0004, r0, 1'b0);
    txn(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    check("swap_at_0", 32'(last_rd[1]), 32'h0007);
    txn(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
    check("swap_at_4", 32'(last_rd[1]), 32'h0005);

    // Random traffic over a pre-initialised pool plus error addresses
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) txn(s[0], 1'b1, 16'(i * 4), 16'($urandom), 1'b0);
      txn(s[0], 1'b1, 16'h0FFC, 16'($urandom), 1'b0);
    end
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        7:       a = 16'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        8:       a = 16'($urandom_range(1024, 16383) * 4);
        9:       a = 16'h0FFC;
        default: a = 16'($urandom_range(0, 15) * 4);
      endcase
      txn(1'($urandom), 1'($urandom), a, 16'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
